// File: rtl/cordic_vector_iter.sv
// Vectoring-mode CORDIC: rotates (Vx,Vy) onto the x axis, two micro-rotations per clock.
// Define CORDIC_GAIN_COMP_EN to add a one-cycle COMP state that removes the CORDIC gain from mag.
//
// state | meaning
// IDLE  | waiting for a vector (in_ready high)
// ITER  | four cycles of paired micro-rotations, counted down by cnt
// COMP  | gain compensation of x into mag (CORDIC_GAIN_COMP_EN only)
// DONE  | result held on mag/angle until out_ready
module cordic_vector_iter (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic signed [18:0]  Vx,
   input  logic signed [18:0]  Vy,
   output logic                out_valid,
   input  logic                out_ready,
   output logic        [19:0]  mag,
   output logic signed [8:0]   angle
);

`ifdef CORDIC_GAIN_COMP_EN
   typedef enum logic [1:0] {IDLE, ITER, COMP, DONE} state_t;
`else
   typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
`endif

   state_t state, state_nxt;

   logic        [1:0]  cnt;
   logic signed [20:0] x, y;
   logic signed [8:0]  z;

   logic signed [20:0] vx_e, vy_e;
   logic signed [20:0] x1, y1, x2, y2;
   logic signed [8:0]  z1, z2;
   logic        [2:0]  i0, i1;
   logic               capture;

   function automatic logic signed [8:0] atan_lut(input logic [2:0] i);
      case (i)
         3'd0:    atan_lut = 9'sd64;
         3'd1:    atan_lut = 9'sd38;
         3'd2:    atan_lut = 9'sd20;
         3'd3:    atan_lut = 9'sd10;
         3'd4:    atan_lut = 9'sd5;
         3'd5:    atan_lut = 9'sd3;
         default: atan_lut = 9'sd1;
      endcase
   endfunction

   assign capture   = in_valid && in_ready;
   assign out_valid = (state == DONE);
   assign vx_e      = {{2{Vx[18]}}, Vx};
   assign vy_e      = {{2{Vy[18]}}, Vy};

   // cnt counts 3..0, so the step pair for this cycle is 2*(3-cnt) and 2*(3-cnt)+1
   assign i0 = {~cnt, 1'b0};
   assign i1 = {~cnt, 1'b1};

   always_comb begin
      x1 = x;
      y1 = y;
      z1 = z;
      x2 = x;
      y2 = y;
      z2 = z;
      if (!y[20]) begin
         x1 = x + (y >>> i0);
         y1 = y - (x >>> i0);
         z1 = z + atan_lut(i0);
      end else begin
         x1 = x - (y >>> i0);
         y1 = y + (x >>> i0);
         z1 = z - atan_lut(i0);
      end
      if (!y1[20]) begin
         x2 = x1 + (y1 >>> i1);
         y2 = y1 - (x1 >>> i1);
         z2 = z1 + atan_lut(i1);
      end else begin
         x2 = x1 - (y1 >>> i1);
         y2 = y1 + (x1 >>> i1);
         z2 = z1 - atan_lut(i1);
      end
   end

`ifdef CORDIC_GAIN_COMP_EN
   logic [19:0] xm, comp;
   // x is non-negative and below 2^20 after the iterations, so the low 20 bits carry it fully
   assign xm   = x[19:0];
   assign comp = (xm >> 1) + (xm >> 3) - (xm >> 6) - (xm >> 9);
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (capture) state_nxt = ITER;
`ifdef CORDIC_GAIN_COMP_EN
         ITER: if (cnt == 2'd0) state_nxt = COMP;
         COMP: state_nxt = DONE;
`else
         ITER: if (cnt == 2'd0) state_nxt = DONE;
`endif
         DONE: if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         in_ready <= 1'b0;
      end else begin
         state    <= state_nxt;
         in_ready <= (state_nxt == IDLE);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= 2'd0;
         x     <= '0;
         y     <= '0;
         z     <= '0;
         mag   <= '0;
         angle <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (capture) begin
                  cnt <= 2'd3;
                  if (!vx_e[20]) begin
                     x <= vx_e;
                     y <= vy_e;
                     z <= 9'sd0;
                  end else if (!vy_e[20]) begin
                     x <= vy_e;
                     y <= -vx_e;
                     z <= 9'sd128;
                  end else begin
                     x <= -vy_e;
                     y <= vx_e;
                     z <= -9'sd128;
                  end
               end
            end
            ITER: begin
               x <= x2;
               y <= y2;
               z <= z2;
               if (cnt != 2'd0) begin
                  cnt <= cnt - 2'd1;
               end
`ifndef CORDIC_GAIN_COMP_EN
               if (cnt == 2'd0) begin
                  mag   <= x2[19:0];
                  angle <= z2;
               end
`endif
            end
`ifdef CORDIC_GAIN_COMP_EN
            COMP: begin
               mag   <= comp;
               angle <= z;
            end
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cordic_vector_iter.sv
// Scoreboard bench for cordic_vector_iter: integer CORDIC reference model, directed accuracy
// cases, backpressure hold, mid-iteration reset and randomized vectors.
module tb_cordic_vector_iter;

`ifdef CORDIC_GAIN_COMP_EN
   localparam int LAT = 5;
`else
   localparam int LAT = 4;
`endif

   logic               clk = 1'b0;
   logic               rst_n;
   logic               in_valid;
   logic               in_ready;
   logic signed [18:0] Vx, Vy;
   logic               out_valid;
   logic               out_ready;
   logic        [19:0] mag;
   logic signed [8:0]  angle;

   cordic_vector_iter dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .Vx(Vx), .Vy(Vy), .out_valid(out_valid), .out_ready(out_ready),
      .mag(mag), .angle(angle)
   );

   always #5 clk = ~clk;

   typedef struct {
      int m;
      int a;
      int cap;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cycle    = 0;
   int   n_out    = 0;
   int   last_mag = 0;
   int   last_ang = 0;
   bit   bp       = 1'b0;
   bit   ov_d     = 1'b0;

   always @(posedge clk) cycle++;

   task automatic check(input bit ok, input string name, input int act, input int exp);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   // Reference: quadrant fold, eight CORDIC steps on plain integers, 9-bit wrap of the angle.
   function automatic void model(input int vx, input int vy, output int m, output int a);
      int atan_t[8] = '{64, 38, 20, 10, 5, 3, 1, 1};
      int x, y, z, nx, ny;
      if (vx >= 0) begin
         x = vx; y = vy; z = 0;
      end else if (vy >= 0) begin
         x = vy; y = -vx; z = 128;
      end else begin
         x = -vy; y = vx; z = -128;
      end
      for (int i = 0; i < 8; i++) begin
         if (y >= 0) begin
            nx = x + (y >>> i); ny = y - (x >>> i); z = z + atan_t[i];
         end else begin
            nx = x - (y >>> i); ny = y + (x >>> i); z = z - atan_t[i];
         end
         x = nx; y = ny;
      end
      z = z & 511;
      a = (z >= 256) ? z - 512 : z;
`ifdef CORDIC_GAIN_COMP_EN
      m = (x >>> 1) + (x >>> 3) - (x >>> 6) - (x >>> 9);
`else
      m = x;
`endif
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         ov_d = 1'b0;
      end else begin
         if (out_valid && !ov_d && sb.size() > 0)
            check(cycle - sb[0].cap == LAT, "latency", cycle - sb[0].cap, LAT);
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check(1'b0, "unexpected_output", int'(mag), -1);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check(int'(mag) == e.m, "sb_mag", int'(mag), e.m);
               check(int'(angle) == e.a, "sb_angle", int'(angle), e.a);
            end
            last_mag = int'(mag);
            last_ang = int'(angle);
            n_out++;
         end
         ov_d = out_valid;
      end
   end

   task automatic send(input int vx, input int vy);
      int t = 0;
      int m, a;
      while (!in_ready && t < 100) begin
         if (bp) out_ready = ($urandom_range(0, 3) != 0);
         @(posedge clk); #1;
         t++;
      end
      if (t >= 100) begin
         check(1'b0, "in_ready_timeout", t, 100);
      end else begin
         model(vx, vy, m, a);
         in_valid = 1'b1;
         Vx = 19'(vx);
         Vy = 19'(vy);
         @(posedge clk); #1;
         sb.push_back('{m, a, cycle});
         in_valid = 1'b0;
         Vx = 19'($urandom);
         Vy = 19'($urandom);
      end
   endtask

   task automatic wait_out(input int prev);
      int t = 0;
      while (n_out == prev && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 200) check(1'b0, "result_timeout", t, 200);
   endtask

   task automatic run_dir(input int vx, input int vy);
      int prev;
      prev = n_out;
      send(vx, vy);
      wait_out(prev);
   endtask

   initial begin
      int hm, ha, prev, t;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; Vx = '0; Vy = '0;
      repeat (3) @(posedge clk);
      #1;
      check(in_ready == 1'b0, "rst_in_ready", int'(in_ready), 0);
      check(out_valid == 1'b0, "rst_out_valid", int'(out_valid), 0);
      check(mag == 20'd0, "rst_mag", int'(mag), 0);
      check(angle == 9'sd0, "rst_angle", int'(angle), 0);
      @(negedge clk) rst_n = 1'b1;
      #1 check(in_ready == 1'b0, "in_ready_before_edge", int'(in_ready), 0);
      @(posedge clk); #1;
      check(in_ready == 1'b1, "in_ready_after_release", int'(in_ready), 1);

      run_dir(1000, 0);
      check(iabs(last_ang) <= 2, "ang_1000_0", last_ang, 0);
`ifdef CORDIC_GAIN_COMP_EN
      check(iabs(last_mag - 1000) <= 8, "mag_1000_0", last_mag, 1000);
`else
      check(iabs(last_mag - 1647) <= 8, "mag_1000_0", last_mag, 1647);
`endif
      run_dir(0, -1000);
      check(iabs(last_ang + 128) <= 2, "ang_0_m1000", last_ang, -128);
      run_dir(-1000, -1000);
      check(iabs(last_ang + 192) <= 2, "ang_m1000_m1000", last_ang, -192);
`ifndef CORDIC_GAIN_COMP_EN
      check(iabs(last_mag - 2329) <= 12, "mag_m1000_m1000", last_mag, 2329);
`endif
      run_dir(-1000, 0);
      check(last_ang == 254 || last_ang == 255 || last_ang == -256 || last_ang == -255,
            "ang_m1000_0", last_ang, -256);
`ifndef CORDIC_GAIN_COMP_EN
      check(iabs(last_mag - 1647) <= 8, "mag_m1000_0", last_mag, 1647);
`endif
      run_dir(-262144, -262144);
      check(iabs(last_ang + 192) <= 2, "ang_fullscale", last_ang, -192);
`ifndef CORDIC_GAIN_COMP_EN
      check(iabs(last_mag - 610000) <= 3000, "mag_fullscale", last_mag, 610000);
`endif

      // backpressure: result held for 10 cycles while new requests are ignored
      out_ready = 1'b0;
      send(3000, -2000);
      t = 0;
      while (!out_valid && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      check(out_valid == 1'b1, "hold_reach_done", int'(out_valid), 1);
      hm = int'(mag);
      ha = int'(angle);
      for (int k = 0; k < 10; k++) begin
         in_valid = 1'b1;
         Vx = 19'($urandom);
         Vy = 19'($urandom);
         check(out_valid == 1'b1, "hold_out_valid", int'(out_valid), 1);
         check(int'(mag) == hm, "hold_mag", int'(mag), hm);
         check(int'(angle) == ha, "hold_angle", int'(angle), ha);
         check(in_ready == 1'b0, "hold_in_ready", int'(in_ready), 0);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      prev = n_out;
      @(posedge clk); #1;
      check(n_out == prev + 1, "consumed_first_cycle", n_out - prev, 1);
      check(out_valid == 1'b0, "out_valid_after_consume", int'(out_valid), 0);

      // reset during the second ITER cycle drops the in-flight vector
      send(5000, 7000);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      check(out_valid == 1'b0, "midrst_out_valid", int'(out_valid), 0);
      check(mag == 20'd0, "midrst_mag", int'(mag), 0);
      check(angle == 9'sd0, "midrst_angle", int'(angle), 0);
      check(in_ready == 1'b0, "midrst_in_ready", int'(in_ready), 0);
      sb.delete();
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      check(in_ready == 1'b1, "midrst_in_ready_release", int'(in_ready), 1);
      repeat (8) @(posedge clk);
      #1 check(out_valid == 1'b0, "midrst_no_result", int'(out_valid), 0);
      run_dir(-1234, 4321);

      // randomized vectors with random consumer stalls
      bp = 1'b1;
      for (int k = 0; k < 40; k++)
         send(int'($urandom_range(0, 524287)) - 262144, int'($urandom_range(0, 524287)) - 262144);
      bp = 1'b0;
      out_ready = 1'b1;
      t = 0;
      while (sb.size() > 0 && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 200) check(1'b0, "drain_timeout", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
